ili9341_spi_rx: RTL and testbench
=================================

// Module: ili9341_spi_rx
// PURPOSE
// - SPI slave/monitor for the 4-wire ILI9341 link (sck, mosi, cs, dc) that
//   the display transmitter drives. It is the receiving end of that link.
// - Deserialises bytes, tags each byte as command or data, and buffers the
//   bytes in a FIFO behind a valid/ready port.
// - Tracks RAMWR pixel streams and flags each completed frame.
// - Sits on-chip as a loopback checker of the display stream; status goes to
//   LEDs and the 7-seg path.
// PARAMETERS
// - FIFO_DEPTH       8      entries; must be a power of 2, >= 2
// - SYNC_STAGES      2      synchroniser flops on each SPI input, >= 2
// - RAMWR_CMD        8'h2C  command byte that opens a pixel stream
// - PIXELS_PER_FRAME 76800  16-bit pixels per frame (320x240)
// PORTS
// - clk           in   1   system clock; all logic on posedge
// - rst           in   1   asynchronous, active-low reset
// - spi_sck       in   1   SPI clock, asynchronous to clk
// - spi_mosi      in   1   serial data, MSB first
// - spi_cs        in   1   chip select, active-low
// - spi_dc        in   1   0 = command byte, 1 = data byte
// - rx_data       out  8   byte at the FIFO head
// - rx_is_cmd     out  1   head byte is a command (dc was 0)
// - rx_valid      out  1   FIFO not empty
// - rx_ready      in   1   consumer accepts the head this cycle
// - last_cmd      out  8   most recent command byte received
// - pixel_count   out  17  pixels completed in the current RAMWR stream
// - frame_done    out  1   1-cycle pulse when a frame completes
// - overflow      out  1   sticky: a byte was dropped because the FIFO was full
// - frame_err     out  1   sticky: cs deasserted with a partial byte
// BEHAVIOUR
// - Reset (rst=0, async): all outputs 0; FIFO empty; bit counter 0;
//   tracker state IDLE. Sticky flags clear only on reset.
// - Input sync: all four SPI inputs pass through SYNC_STAGES flops.
//   - sck rise = synced sck is 1 now and was 0 last cycle.
//   - cs rise = synced cs goes 0 -> 1.
//   - Supported rate: sck high and low time each >= 3 clk periods.
// - Shifting: SPI mode 0. On each sck rise while synced cs = 0:
//   - shift = {shift[6:0], mosi}; bit_cnt += 1 (3-bit counter).
//   - On the 8th rise (bit_cnt = 7 -> 0), the byte completes. dc is sampled
//     on that same cycle.
// - cs high: bit_cnt forced to 0.
//   - If cs rises with bit_cnt != 0: frame_err <= 1 and the partial byte is
//     discarded.
//   - A byte that completed earlier is always kept.
//   - sck edges while cs = 1 are ignored.
// - FIFO push: on byte completion, the byte and its dc tag are pushed.
//   - If full and no pop this cycle: the byte is dropped and overflow <= 1.
//   - If full and a pop happens this cycle: the push is accepted.
// - FIFO pop: first-word-fall-through.
//   - rx_data and rx_is_cmd are valid whenever rx_valid = 1.
//   - A pop occurs on rx_valid & rx_ready.
//   - rx_ready while empty has no effect.
// - Latency: rx_valid rises 1 clk after the push cycle. Total delay from the
//   raw 8th sck edge is <= SYNC_STAGES+2 clk.
// - Pointers wrap modulo FIFO_DEPTH; a separate count tracks full/empty.
// - Tracker: driven by completed bytes, independent of FIFO pops and drops.
//   States are IDLE, PIX_HI, PIX_LO.
//   - Any command byte: last_cmd <= byte.
//     - If the byte == RAMWR_CMD: go to PIX_HI and set pixel_count <= 0.
//     - Otherwise: go to IDLE; pixel_count holds its value.
//   - Data byte in IDLE: ignored.
//   - Data byte in PIX_HI: go to PIX_LO.
//   - Data byte in PIX_LO: go to PIX_HI and increment pixel_count.
//     - If the increment reaches PIXELS_PER_FRAME: frame_done = 1 for one
//       cycle, pixel_count <= 0, and the state stays in the stream (PIX_HI).
// - Reset mid-byte or mid-frame aborts everything immediately. The next byte
//   is taken from the first sck rise after cs is seen low.
// TESTING
// - Reset, then send 0xA5 with dc=0 at sck = clk/8 ->
//   rx_valid=1, rx_data=8'hA5, rx_is_cmd=1, last_cmd=8'hA5.
// - With rx_ready=0, send 9 bytes 0x01..0x09 (dc=1) ->
//   overflow=1, FIFO holds 0x01..0x08.
//   Then hold rx_ready=1 -> pops return 0x01..0x08 in order, then rx_valid=0.
// - Send 5 bits, then raise cs ->
//   frame_err=1, no push.
//   Then send 0x3C -> received as 0x3C.
// - Send 0x2C (cmd), then 4 data bytes ->
//   pixel_count=2.
//   Then send 0x2A (cmd) -> state IDLE, pixel_count stays 2, last_cmd=8'h2A.
// - With PIXELS_PER_FRAME=4: send 0x2C, then 8 data bytes ->
//   frame_done pulses once and pixel_count=0.
//   Then 2 more data bytes -> pixel_count=1.
// - Hold rx_ready=1 throughout: every completed byte is popped one cycle
//   after rx_valid rises; overflow stays 0.
//   Then assert rst mid-byte -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/ili9341_spi_rx.sv
// Receiving end of the ILI9341 4-wire SPI link: deserialises bytes, tags cmd/data, tracks RAMWR frames.
// Latency: a byte is pushed SYNC_STAGES+1 clk after the raw 8th sck edge at most; rx_valid follows 1 clk later.
// Backpressure: rx_ready pops a first-word-fall-through FIFO; a byte arriving while full and not popping is dropped (overflow).
//
// Ports:
//   clk, rst            system clock (posedge), asynchronous active-low reset
//   spi_sck/mosi/cs/dc  raw SPI link inputs, asynchronous to clk (mode 0, MSB first, cs active-low)
//   rx_data/rx_is_cmd   byte at the FIFO head and its command tag, valid while rx_valid
//   rx_valid/rx_ready   FIFO not empty / consumer accepts the head this cycle
//   last_cmd            most recent command byte
//   pixel_count         pixels completed in the current RAMWR stream
//   frame_done          1-cycle pulse when a full frame of pixels has been received
//   overflow, frame_err sticky error flags (dropped byte / cs raised mid-byte)
module ili9341_spi_rx #(
  parameter int          FIFO_DEPTH       = 8,
  parameter int          SYNC_STAGES      = 2,
  parameter logic [7:0]  RAMWR_CMD        = 8'h2C,
  parameter int          PIXELS_PER_FRAME = 76800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  input  logic        spi_cs,
  input  logic        spi_dc,
  output logic [7:0]  rx_data,
  output logic        rx_is_cmd,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [7:0]  last_cmd,
  output logic [16:0] pixel_count,
  output logic        frame_done,
  output logic        overflow,
  output logic        frame_err
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = AW + 1;
  localparam logic [16:0] FRAME_PIX = 17'(PIXELS_PER_FRAME);

  // ---------------------------------------------------------------------------
  // Input synchronisers. cs resets to the idle (deselected) level so that a
  // link already selected at reset release is seen as a fresh selection.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] dc_sync;
  logic                   sck_d;
  logic                   cs_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      dc_sync   <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], spi_dc};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  logic sck_s, mosi_s, cs_s, dc_s;
  logic sck_rise, cs_rise;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign dc_s     = dc_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign cs_rise  = cs_s & ~cs_d;

  // ---------------------------------------------------------------------------
  // Deserialiser. Only 7 bits are stored: the 8th bit is taken straight from
  // mosi on the completing edge, so the full byte is available that cycle.
  // ---------------------------------------------------------------------------
  logic [6:0] shift;
  logic [2:0] bit_cnt;
  logic       byte_done;
  logic [7:0] byte_val;
  logic       byte_cmd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift     <= '0;
      bit_cnt   <= '0;
      frame_err <= 1'b0;
    end else if (cs_s) begin
      bit_cnt <= '0;
      if (cs_rise && bit_cnt != 3'd0) begin
        frame_err <= 1'b1;
      end
    end else if (sck_rise) begin
      shift   <= {shift[5:0], mosi_s};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  assign byte_done = ~cs_s & sck_rise & (bit_cnt == 3'd7);
  assign byte_val  = {shift, mosi_s};
  assign byte_cmd  = ~dc_s;

  // ---------------------------------------------------------------------------
  // FIFO: first-word-fall-through, pointers wrap naturally at AW bits, count
  // disambiguates full from empty. A pop in the same cycle frees the slot a
  // push into a full FIFO needs.
  // ---------------------------------------------------------------------------
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign pop        = ~fifo_empty & rx_ready;
  assign push       = byte_done & (~fifo_full | pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {byte_cmd, byte_val};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (byte_done && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Head is forced to zero while empty so stale RAM never shows after reset.
  logic [8:0] head;
  assign head      = fifo_empty ? 9'd0 : mem[rd_ptr];
  assign rx_data   = head[7:0];
  assign rx_is_cmd = head[8];
  assign rx_valid  = ~fifo_empty;

  // ---------------------------------------------------------------------------
  // RAMWR tracker. Fed by every completed byte, including ones the FIFO drops,
  // so the pixel count reflects the link rather than the consumer.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PIX_HI = 2'd1,
    PIX_LO = 2'd2
  } trk_state_t;

  trk_state_t  state, state_nxt;
  logic [7:0]  last_cmd_nxt;
  logic [16:0] pixel_count_nxt;
  logic        frame_done_nxt;
  logic [16:0] pixel_inc;

  assign pixel_inc = pixel_count + 17'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (byte_done) begin
      if (byte_cmd) begin
        state_nxt = (byte_val == RAMWR_CMD) ? PIX_HI : IDLE;
      end else begin
        case (state)
          PIX_HI:  state_nxt = PIX_LO;
          PIX_LO:  state_nxt = PIX_HI;
          default: state_nxt = state;
        endcase
      end
    end
  end

  always_comb begin
    last_cmd_nxt    = last_cmd;
    pixel_count_nxt = pixel_count;
    frame_done_nxt  = 1'b0;
    if (byte_done) begin
      if (byte_cmd) begin
        last_cmd_nxt = byte_val;
        if (byte_val == RAMWR_CMD) begin
          pixel_count_nxt = '0;
        end
      end else if (state == PIX_LO) begin
        // Frame wrap keeps the stream open: the next pixel starts a new frame.
        if (pixel_inc == FRAME_PIX) begin
          pixel_count_nxt = '0;
          frame_done_nxt  = 1'b1;
        end else begin
          pixel_count_nxt = pixel_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_cmd    <= '0;
      pixel_count <= '0;
      frame_done  <= 1'b0;
    end else begin
      last_cmd    <= last_cmd_nxt;
      pixel_count <= pixel_count_nxt;
      frame_done  <= frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_ili9341_spi_rx.sv
// Bench for ili9341_spi_rx: scoreboard on the FIFO output plus table-driven tracker checks.
// Latency: expectations sampled on clk negedge, a few clk after each SPI byte finishes.
// Backpressure: rx_ready toggled by the bench to exercise hold, overflow and drain.
module tb_ili9341_spi_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_dc = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_is_cmd;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [7:0]  last_cmd;
  logic [16:0] pixel_count;
  logic        frame_done;
  logic        overflow;
  logic        frame_err;

  ili9341_spi_rx #(
    .FIFO_DEPTH       (8),
    .SYNC_STAGES      (2),
    .RAMWR_CMD        (8'h2C),
    .PIXELS_PER_FRAME (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_cs      (spi_cs),
    .spi_dc      (spi_dc),
    .rx_data     (rx_data),
    .rx_is_cmd   (rx_is_cmd),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .last_cmd    (last_cmd),
    .pixel_count (pixel_count),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       is_cmd;
  } sb_t;

  typedef struct {
    logic [7:0]  b;
    logic        dc;
    logic [7:0]  exp_cmd;
    logic [16:0] exp_pix;
    int          exp_fd;
  } vec_t;

  sb_t  sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   fd_count = 0;
  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every pop the DUT performs is compared with the oldest expected byte.
  always @(negedge clk) begin
    if (rst && rx_valid && rx_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL pop_unexpected: got %0h, expected no byte", rx_data);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("pop_data", {24'd0, rx_data}, {24'd0, e.data});
        chk("pop_is_cmd", {31'd0, rx_is_cmd}, {31'd0, e.is_cmd});
      end
    end
    if (rst && frame_done) fd_count++;
  end

  // sck = clk/8: 40 time units each phase with a 10-unit clk period.
  task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits);
    spi_dc = dc;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = b[i];
      #40;
      spi_sck = 1'b1;
      #40;
      spi_sck = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc, input logic expect_push);
    sb_t e;
    e.data   = b;
    e.is_cmd = ~dc;
    if (expect_push) sb.push_back(e);
    send_bits(b, dc, 8);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1;
    rx_ready = v;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d bytes left, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic cs_release();
    #40;
    spi_cs = 1'b1;
    #80;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rx_valid"},    {31'd0, rx_valid},    32'd0);
    chk({tag, "_rx_data"},     {24'd0, rx_data},     32'd0);
    chk({tag, "_rx_is_cmd"},   {31'd0, rx_is_cmd},   32'd0);
    chk({tag, "_last_cmd"},    {24'd0, last_cmd},    32'd0);
    chk({tag, "_pixel_count"}, {15'd0, pixel_count}, 32'd0);
    chk({tag, "_frame_done"},  {31'd0, frame_done},  32'd0);
    chk({tag, "_overflow"},    {31'd0, overflow},    32'd0);
    chk({tag, "_frame_err"},   {31'd0, frame_err},   32'd0);
  endtask

  initial begin
    int fd0;

    // Tracker vectors: byte, dc, then expected last_cmd / pixel_count / frame pulses seen.
    tbl[0]  = '{8'h2C, 1'b0, 8'h2C, 17'd0, 0};
    tbl[1]  = '{8'h11, 1'b1, 8'h2C, 17'd0, 0};
    tbl[2]  = '{8'h22, 1'b1, 8'h2C, 17'd1, 0};
    tbl[3]  = '{8'h33, 1'b1, 8'h2C, 17'd1, 0};
    tbl[4]  = '{8'h44, 1'b1, 8'h2C, 17'd2, 0};
    tbl[5]  = '{8'h2A, 1'b0, 8'h2A, 17'd2, 0};
    tbl[6]  = '{8'h2C, 1'b0, 8'h2C, 17'd0, 0};
    tbl[7]  = '{8'h80, 1'b1, 8'h2C, 17'd0, 0};
    tbl[8]  = '{8'h81, 1'b1, 8'h2C, 17'd1, 0};
    tbl[9]  = '{8'h82, 1'b1, 8'h2C, 17'd1, 0};
    tbl[10] = '{8'h83, 1'b1, 8'h2C, 17'd2, 0};
    tbl[11] = '{8'h84, 1'b1, 8'h2C, 17'd2, 0};
    tbl[12] = '{8'h85, 1'b1, 8'h2C, 17'd3, 0};
    tbl[13] = '{8'h86, 1'b1, 8'h2C, 17'd3, 0};
    tbl[14] = '{8'h87, 1'b1, 8'h2C, 17'd0, 1};
    tbl[15] = '{8'h88, 1'b1, 8'h2C, 17'd0, 1};
    tbl[16] = '{8'h89, 1'b1, 8'h2C, 17'd1, 1};

    // Reset state
    #23;
    check_all_zero("reset");
    rst = 1'b1;
    repeat (3) @(posedge clk);

    // Single command byte, held at the head
    spi_cs = 1'b0;
    #40;
    send_byte(8'hA5, 1'b0, 1'b1);
    chk("a5_rx_valid",  {31'd0, rx_valid},  32'd1);
    chk("a5_rx_data",   {24'd0, rx_data},   32'hA5);
    chk("a5_rx_is_cmd", {31'd0, rx_is_cmd}, 32'd1);
    chk("a5_last_cmd",  {24'd0, last_cmd},  32'hA5);
    set_ready(1'b1);
    drain();
    set_ready(1'b0);

    // Nine bytes into an eight-deep FIFO with no consumer
    for (int i = 1; i <= 9; i++) begin
      send_byte(8'(i), 1'b1, i <= 8);
    end
    chk("ovf_overflow", {31'd0, overflow}, 32'd1);
    chk("ovf_head",     {24'd0, rx_data},  32'h01);
    set_ready(1'b1);
    drain();
    chk("ovf_empty_after", {31'd0, rx_valid}, 32'd0);
    cs_release();
    chk("pre_frame_err", {31'd0, frame_err}, 32'd0);

    // Partial byte aborted by cs, then a clean byte
    spi_cs = 1'b0;
    #40;
    send_bits(8'hF8, 1'b1, 5);
    cs_release();
    repeat (4) @(posedge clk);
    #1;
    chk("partial_frame_err", {31'd0, frame_err}, 32'd1);
    chk("partial_no_push",   {31'd0, rx_valid},  32'd0);
    spi_cs = 1'b0;
    #80;
    send_byte(8'h3C, 1'b1, 1'b1);
    drain();

    // Tracker table (PIXELS_PER_FRAME = 4), consumer always ready
    fd0 = fd_count;
    for (int i = 0; i < 17; i++) begin
      send_byte(tbl[i].b, tbl[i].dc, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("trk%0d_last_cmd", i),    {24'd0, last_cmd},    {24'd0, tbl[i].exp_cmd});
      chk($sformatf("trk%0d_pixel_count", i), {15'd0, pixel_count}, {15'd0, tbl[i].exp_pix});
      chk($sformatf("trk%0d_frame_done", i),  32'(fd_count - fd0),  32'(tbl[i].exp_fd));
    end
    drain();
    cs_release();

    // Fresh reset, consumer always ready, then reset in the middle of a byte
    rst = 1'b0;
    sb.delete();
    #20;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    set_ready(1'b1);
    spi_cs = 1'b0;
    #40;
    send_byte(8'h2C, 1'b0, 1'b1);
    send_byte(8'hAB, 1'b1, 1'b1);
    send_byte(8'hCD, 1'b1, 1'b1);
    drain();
    chk("stream_overflow",    {31'd0, overflow},    32'd0);
    chk("stream_pixel_count", {15'd0, pixel_count}, 32'd1);
    send_bits(8'hE0, 1'b1, 3);
    #7;
    rst = 1'b0;
    sb.delete();
    #1;
    check_all_zero("midbyte_rst");
    #20;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    send_byte(8'h5A, 1'b1, 1'b1);
    drain();
    chk("post_rst_last_cmd",  {24'd0, last_cmd},  32'd0);
    chk("post_rst_frame_err", {31'd0, frame_err}, 32'd0);
    cs_release();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule
